// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU / multiply-divide unit:
// operation encodings, sequencer states and small decode helpers.
package alu_pkg;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_ADDU  = 5'd1;
  localparam logic [4:0] OP_SUB   = 5'd2;
  localparam logic [4:0] OP_SUBU  = 5'd3;
  localparam logic [4:0] OP_SLT   = 5'd4;
  localparam logic [4:0] OP_SLTU  = 5'd5;
  localparam logic [4:0] OP_AND   = 5'd6;
  localparam logic [4:0] OP_OR    = 5'd7;
  localparam logic [4:0] OP_XOR   = 5'd8;
  localparam logic [4:0] OP_NOR   = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;
  localparam logic [4:0] OP_LUI   = 5'd13;
  localparam logic [4:0] OP_MFHI  = 5'd14;
  localparam logic [4:0] OP_MFLO  = 5'd15;
  localparam logic [4:0] OP_MTHI  = 5'd16;
  localparam logic [4:0] OP_MTLO  = 5'd17;
  localparam logic [4:0] OP_MULT  = 5'd18;
  localparam logic [4:0] OP_MULTU = 5'd19;
  localparam logic [4:0] OP_DIV   = 5'd20;
  localparam logic [4:0] OP_DIVU  = 5'd21;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic is_mdu_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_mdu_op(input logic [4:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Issue/result bundle between the ID/EX operand latch and the ALU/MDU.
interface alu_mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       oper;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             out_valid;
  logic [WIDTH-1:0] result;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, oper, a, b, flush,
    input  in_ready, out_valid, result, overflow, busy
  );

  modport slave (
    input  in_valid, oper, a, b, flush,
    output in_ready, out_valid, result, overflow, busy
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply / restoring-divide datapath. Works on operand
// magnitudes and applies sign correction combinationally on the final state.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step,
  input  logic [4:0]       oper,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             last,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  // acc_hi: partial product high / remainder; acc_lo: multiplier / dividend-quotient
  logic [WIDTH-1:0] acc_hi_q, acc_lo_q, m_q;
  logic [SHW-1:0]   cnt_q;
  logic             div_q, neg_lo_q, neg_hi_q, dz_q;

  logic [WIDTH:0]     mul_sum, div_shift, div_trial;
  logic [2*WIDTH-1:0] prod, prod_fix;

  assign a_neg = is_signed_mdu_op(oper) & a[WIDTH-1];
  assign b_neg = is_signed_mdu_op(oper) & b[WIDTH-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, m_q} : '0);
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_trial = div_shift - {1'b0, m_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
    end else if (start) begin
      acc_hi_q <= '0;
      acc_lo_q <= mag_a;
      m_q      <= mag_b;
      cnt_q    <= SHW'(WIDTH - 1);
      div_q    <= is_div_op(oper);
      neg_lo_q <= a_neg ^ b_neg;
      neg_hi_q <= a_neg;
      dz_q     <= (b == '0);
    end else if (step) begin
      cnt_q <= cnt_q - 1'b1;
      if (div_q) begin
        // A borrow out of the trial subtract means the divisor did not fit.
        acc_hi_q <= div_trial[WIDTH] ? div_shift[WIDTH-1:0] : div_trial[WIDTH-1:0];
        acc_lo_q <= {acc_lo_q[WIDTH-2:0], ~div_trial[WIDTH]};
      end else begin
        {acc_hi_q, acc_lo_q} <= {mul_sum, acc_lo_q[WIDTH-1:1]};
      end
    end
  end

  assign last     = (cnt_q == '0);
  assign prod     = {acc_hi_q, acc_lo_q};
  assign prod_fix = neg_lo_q ? -prod : prod;

  always_comb begin
    hi = prod_fix[2*WIDTH-1:WIDTH];
    lo = prod_fix[WIDTH-1:0];
    if (div_q) begin
      // Divide by zero leaves |a| in the remainder, which the dividend-sign
      // fix-up turns back into a.
      lo = dz_q ? '1 : (neg_lo_q ? -acc_lo_q : acc_lo_q);
      hi = neg_hi_q ? -acc_hi_q : acc_hi_q;
    end
  end

endmodule

// File: rtl/alu_mdu.sv
// Execute-stage ALU with single-cycle integer ops, architectural HI/LO and an
// iterative multiply/divide sequencer that stalls issue while active.
module alu_mdu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned SHW = $clog2(WIDTH)
) (
  input logic       clk,
  input logic       rst,
  alu_mdu_if.slave  bus
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] hi_q, lo_q, res_q;
  logic             ovf_q, vld_q;

  logic             ready, accept, mdu_op, done_ok;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_ovf;
  logic [SHW-1:0]   shamt;

  logic             mdu_last;
  logic [WIDTH-1:0] mdu_hi, mdu_lo;

  assign ready  = (state_q == ST_IDLE);
  assign accept = bus.in_valid & ready & ~bus.flush;
  assign mdu_op = is_mdu_op(bus.oper);
  assign sum    = bus.a + bus.b;
  assign diff   = bus.a - bus.b;
  assign shamt  = bus.b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (bus.oper)
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_ADDU: alu_res = sum;
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (diff[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUBU: alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (bus.a < bus.b)};
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_NOR:  alu_res = ~(bus.a | bus.b);
      OP_SLL:  alu_res = bus.a << shamt;
      OP_SRL:  alu_res = bus.a >> shamt;
      OP_SRA:  alu_res = WIDTH'($signed(bus.a) >>> shamt);
      OP_LUI:  alu_res = {bus.b[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_MFHI: alu_res = hi_q;
      OP_MFLO: alu_res = lo_q;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (accept && mdu_op) state_d = ST_CALC;
      ST_CALC: begin
        if (bus.flush)     state_d = ST_IDLE;
        else if (mdu_last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      hi_q    <= '0;
      lo_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= accept & ~mdu_op;
      if (accept && !mdu_op) begin
        res_q <= alu_res;
        ovf_q <= alu_ovf;
      end
      if (accept && bus.oper == OP_MTHI) hi_q <= bus.a;
      if (accept && bus.oper == OP_MTLO) lo_q <= bus.a;
      if (done_ok) begin
        hi_q <= mdu_hi;
        lo_q <= mdu_lo;
      end
    end
  end

  mdu_iter #(
    .WIDTH (WIDTH)
  ) u_mdu_iter (
    .clk   (clk),
    .rst   (rst),
    .start (accept & mdu_op),
    .step  (state_q == ST_CALC),
    .oper  (bus.oper),
    .a     (bus.a),
    .b     (bus.b),
    .last  (mdu_last),
    .hi    (mdu_hi),
    .lo    (mdu_lo)
  );

  // A flush in the completion cycle must retract that cycle's result.
  assign done_ok       = (state_q == ST_DONE) & ~bus.flush;
  assign bus.in_ready  = ready;
  assign bus.out_valid = vld_q | done_ok;
  assign bus.result    = (state_q == ST_DONE) ? mdu_lo : res_q;
  assign bus.overflow  = vld_q & ovf_q;
  assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_mdu.sv
// Self-checking bench for alu_mdu: vector table issued back-to-back plus
// hand-written multi-cycle, flush and reset sequences, checked by a scoreboard.
module tb_alu_mdu;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_mdu_if #(.WIDTH(32)) bus ();

  alu_mdu #(
    .WIDTH (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ovf;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_out_valid: result=%h, no result expected", bus.result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (bus.result !== e.res || bus.overflow !== e.ovf) begin
          n_bad++;
          $display("FAIL %s: got result=%h ovf=%b, expected result=%h ovf=%b",
                   e.name, bus.result, bus.overflow, e.res, e.ovf);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic add_vec(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] res, logic ovf);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.res = res; v.ovf = ovf;
    tbl.push_back(v);
  endtask

  task automatic push_exp(string name, logic [31:0] res, logic ovf);
    exp_t e;
    e.name = name; e.res = res; e.ovf = ovf;
    exp_q.push_back(e);
  endtask

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic issue(logic [4:0] op, logic [31:0] a, logic [31:0] b, logic fl);
    bus.in_valid = 1'b1;
    bus.oper     = op;
    bus.a        = a;
    bus.b        = b;
    bus.flush    = fl;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
  endtask

  task automatic op1(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                     logic [31:0] res, logic ovf);
    push_exp(name, res, ovf);
    issue(op, a, b, 1'b0);
  endtask

  task automatic wait_idle(string name);
    int k;
    k = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check({name, "_ready_timeout"}, {31'd0, bus.in_ready}, 32'd1);
  endtask

  task automatic mdu_run(string name, logic [4:0] op, logic [31:0] a, logic [31:0] b,
                         logic [31:0] lo, logic [31:0] hi);
    push_exp({name, "_lo"}, lo, 1'b0);
    issue(op, a, b, 1'b0);
    wait_idle(name);
    op1({name, "_mfhi"}, OP_MFHI, 32'd0, 32'd0, hi, 1'b0);
    op1({name, "_mflo"}, OP_MFLO, 32'd0, 32'd0, lo, 1'b0);
  endtask

  initial begin
    logic ok_ready;
    int   ov_cycle;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.oper     = OP_ADD;
    bus.a        = '0;
    bus.b        = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_result",    bus.result,              32'd0);
    check("rst_overflow",  {31'd0, bus.overflow},  32'd0);
    check("rst_busy",      {31'd0, bus.busy},      32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);

    add_vec("add_ovf",   OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1);
    add_vec("addu",      OP_ADDU, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0);
    add_vec("sub",       OP_SUB,  32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0);
    add_vec("slt",       OP_SLT,  32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0);
    add_vec("sra",       OP_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 1'b0);
    add_vec("sub_ovf",   OP_SUB,  32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1);
    add_vec("subu",      OP_SUBU, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b0);
    add_vec("sltu",      OP_SLTU, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    add_vec("and",       OP_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    add_vec("or",        OP_OR,   32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0);
    add_vec("xor",       OP_XOR,  32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0);
    add_vec("nor",       OP_NOR,  32'd0,         32'd0,         32'hFFFF_FFFF, 1'b0);
    add_vec("sll",       OP_SLL,  32'd1,         32'h0000_0023, 32'd8,         1'b0);
    add_vec("srl",       OP_SRL,  32'h8000_0000, 32'd31,        32'd1,         1'b0);
    add_vec("lui",       OP_LUI,  32'h5555_5555, 32'hABCD_1234, 32'h1234_0000, 1'b0);
    add_vec("add_ovf_n", OP_ADD,  32'h8000_0000, 32'h8000_0000, 32'd0,         1'b1);
    add_vec("add_wrap",  OP_ADD,  32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
    add_vec("undef",     5'd31,   32'd1,         32'd2,         32'd0,         1'b0);
    add_vec("mtlo",      OP_MTLO, 32'h0000_CAFE, 32'd0,         32'd0,         1'b0);
    add_vec("mflo",      OP_MFLO, 32'd0,         32'd0,         32'h0000_CAFE, 1'b0);
    add_vec("mthi",      OP_MTHI, 32'h0000_BEEF, 32'd0,         32'd0,         1'b0);
    add_vec("mfhi",      OP_MFHI, 32'd0,         32'd0,         32'h0000_BEEF, 1'b0);

    #1;
    for (int i = 0; i < tbl.size(); i++) begin
      push_exp(tbl[i].name, tbl[i].res, tbl[i].ovf);
      bus.in_valid = 1'b1;
      bus.oper     = tbl[i].op;
      bus.a        = tbl[i].a;
      bus.b        = tbl[i].b;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    @(negedge clk);

    // MULT latency: accept edge ends cycle 0, result in cycle 33.
    push_exp("mult_lo", 32'hFFFF_FFEB, 1'b0);
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    ok_ready = 1'b1;
    ov_cycle = -1;
    for (int c = 1; c <= 33; c++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0) ok_ready = 1'b0;
      if (bus.out_valid === 1'b1 && ov_cycle < 0) ov_cycle = c;
    end
    check("mult_in_ready_low", {31'd0, ok_ready}, 32'd1);
    check("mult_out_valid_cycle", ov_cycle, 32'd33);
    @(negedge clk);
    check("mult_ready_again", {31'd0, bus.in_ready}, 32'd1);
    op1("mult_mfhi", OP_MFHI, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0);
    op1("mult_mflo", OP_MFLO, 32'd0, 32'd0, 32'hFFFF_FFEB, 1'b0);

    mdu_run("div_neg",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF);
    mdu_run("divu_z",   OP_DIVU,  32'd9,         32'd0,         32'hFFFF_FFFF, 32'd9);
    mdu_run("div_z_n",  OP_DIV,   32'hFFFF_FFF6, 32'd0,         32'hFFFF_FFFF, 32'hFFFF_FFF6);
    mdu_run("div_min",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
    mdu_run("multu_mx", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFE);
    mdu_run("divu",     OP_DIVU,  32'd100,       32'd7,         32'd14,        32'd2);

    // Flush in IDLE drops the same-cycle accept.
    issue(OP_ADD, 32'd1, 32'd2, 1'b1);
    @(negedge clk);
    check("flush_idle_no_valid", {31'd0, bus.out_valid}, 32'd0);

    // Flush during CALC: HI keeps the MTHI value.
    op1("mthi_1234", OP_MTHI, 32'h0000_1234, 32'd0, 32'd0, 1'b0);
    issue(OP_DIVU, 32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_calc_ready", {31'd0, bus.in_ready}, 32'd1);
    check("flush_calc_busy",  {31'd0, bus.busy},     32'd0);
    op1("flush_calc_mfhi", OP_MFHI, 32'd0, 32'd0, 32'h0000_1234, 1'b0);

    // Flush in the DONE cycle retracts out_valid and leaves LO untouched.
    issue(OP_MULTU, 32'd2, 32'd3, 1'b0);
    repeat (32) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    check("flush_done_no_valid", {31'd0, bus.out_valid}, 32'd0);
    check("flush_done_busy",     {31'd0, bus.busy},      32'd1);
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_done_ready", {31'd0, bus.in_ready}, 32'd1);
    op1("flush_done_mflo", OP_MFLO, 32'd0, 32'd0, 32'd14, 1'b0);

    // Reset mid-MULTU clears the sequencer and HI/LO.
    issue(OP_MULTU, 32'd5, 32'd6, 1'b0);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_busy",  {31'd0, bus.busy},      32'd0);
    check("rst_mid_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_mid_ready", {31'd0, bus.in_ready},  32'd1);
    op1("rst_mid_mflo", OP_MFLO, 32'd0, 32'd0, 32'd0, 1'b0);
    op1("rst_mid_mfhi", OP_MFHI, 32'd0, 32'd0, 32'd0, 1'b0);

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
